keypad_4x4_scan: RTL and testbench
==================================

Name: keypad_4x4_scan

Overview:
- Input-side counterpart of the 4-digit FND scanner: drives a 4x4 matrix keypad with an active-low ring-scanned column strobe and reads the active-low row lines.
- Synchronizes and debounces the row lines, then encodes each accepted press into a 4-bit key code.
- Presents the code to the CPU/top level through a valid/ack handshake, alongside the display path.

Parameters:
- SCAN_DIV_BITS, 17, width of the free-running scan divider; one scan tick every 2^SCAN_DIV_BITS clk cycles (about 1.05 ms at 8 ns).
- DEBOUNCE_SCANS, 4, consecutive matching ticks needed to accept a press, and consecutive all-high ticks needed to accept a release (range 1..15).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-low reset
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous
- col  output  4  column strobe, active-low one-hot
- key_value  output  4  code of the last accepted key = row_index*4 + col_index
- key_valid  output  1  level; high while an unacknowledged key is held in key_value
- key_ack  input  1  consumer acknowledge, sampled on posedge
- key_pressed  output  1  high while the accepted key is still held (PRESSED or RELEASE state)
- overrun  output  1  sticky; a new key was accepted while key_valid was high

Behaviour:
- Reset (rst==0 at a posedge):
  - col=4'b1110, key_value=0, key_valid=0, key_pressed=0, overrun=0.
  - Divider=0, state=SCAN, debounce count=0, both synchronizer stages=4'b1111.
  - Reset mid-operation discards any candidate or held key.
- Synchronizer: row passes through a 2-FF synchronizer (rs). Only rs is ever sampled.
- Divider: counts up, wrapping at 2^SCAN_DIV_BITS. tick=1 for exactly the one cycle in which the divider is all-ones.
- Column index c: 0 for 1110, 1 for 1101, 2 for 1011, 3 for 0111.
- Row index r: the lowest index with rs[r]==0. Multiple rows low resolves to the lowest r.
- All state actions below occur only on tick cycles.
- SCAN:
  - If rs==4'b1111: rotate col 1110->1101->1011->0111->1110.
  - Otherwise: cand={r,c}, cnt=1, col held, go to DEBOUNCE.
- DEBOUNCE (col held):
  - Sampled code equals cand: cnt++.
  - When cnt reaches DEBOUNCE_SCANS, accept: key_value=cand, key_valid=1, go to PRESSED.
  - If DEBOUNCE_SCANS==1, acceptance happens on the same tick that leaves SCAN.
  - rs all high or a different code: go to SCAN and rotate col.
- PRESSED (col held): rs==4'b1111 gives cnt=1, go to RELEASE. Otherwise stay.
- RELEASE (col held):
  - rs==4'b1111: cnt++. At DEBOUNCE_SCANS, go to SCAN and rotate col.
  - Any row low: go to PRESSED with no new event.
- key_pressed=1 exactly in PRESSED and RELEASE.
- Handshake:
  - Acceptance drives the outputs at the posedge of the tick cycle (registered, latency 0 after the qualifying tick).
  - key_ack=1 with no acceptance in the same cycle: key_valid=0, overrun=0.
  - Acceptance while key_valid=1 and key_ack=0: key_value is overwritten, key_valid stays 1, overrun=1.
  - Acceptance and key_ack=1 in the same cycle: key_valid=1 with the new code, overrun=0.
  - key_ack while key_valid=0 has no effect.
- Exactly one key event per press, except as described under Optional Feature.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - While in PRESSED, a repeat counter counts ticks.
  - After 500 ticks the same code is re-accepted, then again every 100 ticks, using the normal handshake and overrun rules.
  - The counter clears on entering PRESSED and on reset.
- KEYPAD_REPEAT_EN undefined: no repeat logic is present; one event per press.

Test Plan (SCAN_DIV_BITS=4, i.e. tick every 16 clk; DEBOUNCE_SCANS=3; the bench models the matrix: row[r]=0 iff key(r,c) is pressed and col[c]==0):
- Reset: hold rst=0 for 3 cycles, then rst=1 -> col=1110, key_valid=0, key_value=0, overrun=0; col steps 1110->1101->1011->0111->1110 every 16 clk.
- Press key r=1,c=2 and hold -> key_value=4'h6, key_valid=1 on the 3rd matching tick; assert key_ack -> key_valid=0 next cycle; holding 50 ticks gives no further event (repeat disabled).
- Bounce: key r=3,c=0 low for 1 tick, then released -> key_valid stays 0 and col resumes rotation at that tick.
- Overrun: press and release key 0x5, then key 0xA, with no ack -> key_value=4'hA, key_valid=1, overrun=1; a single key_ack cycle -> key_valid=0, overrun=0.
- key_ack asserted in the exact acceptance cycle of key 0xF while key 0x3 is pending -> key_value=4'hF, key_valid=1, overrun=0.
- rst=0 while in PRESSED with key_valid=1 -> next cycle all outputs are at reset values; key still held -> the press is re-detected and re-accepted after 3 ticks.

Source files
------------

// File: rtl/keypad_4x4_scan.sv
// keypad_4x4_scan: ring-scans a 4x4 active-low keypad, debounces presses and
// releases, and hands each accepted key code to the consumer via valid/ack.
// Ports: clk; rst (sync, active-low); row[3:0] in (async, active-low);
// col[3:0] out (active-low one-hot); key_value[3:0] = row*4+col;
// key_valid level, cleared by key_ack; key_pressed while key is held;
// overrun sticky until ack.
// Option: define KEYPAD_REPEAT_EN for auto-repeat (500 ticks, then every 100).
module keypad_4x4_scan #(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_pressed,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_PRESS,
    S_REL
  } state_e;

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
  localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = SCAN_DIV_BITS'(1);

  logic [3:0] rs1_q, rs1_d;
  logic [3:0] rs_q, rs_d;
  logic [SCAN_DIV_BITS-1:0] div_q, div_d;
  state_e     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_value_q, key_value_d;
  logic       key_valid_q, key_valid_d;
  logic       overrun_q, overrun_d;

`ifdef KEYPAD_REPEAT_EN
  logic [8:0] rpt_q, rpt_d;
  logic       rpt_again_q, rpt_again_d;
  logic [8:0] rpt_inc;
`endif

  logic       tick;
  logic       row_any;
  logic [1:0] r_idx;
  logic [1:0] c_idx;
  logic [3:0] code;
  logic [3:0] col_rot;
  logic [3:0] cnt_inc;
  logic       accept;
  logic [3:0] acc_code;

  // Lowest row wins when several rows read low.
  always_comb begin
    r_idx = 2'd3;
    if (!rs_q[0]) begin
      r_idx = 2'd0;
    end else if (!rs_q[1]) begin
      r_idx = 2'd1;
    end else if (!rs_q[2]) begin
      r_idx = 2'd2;
    end
  end

  always_comb begin
    c_idx = 2'd0;
    case (col_q)
      4'b1101: c_idx = 2'd1;
      4'b1011: c_idx = 2'd2;
      4'b0111: c_idx = 2'd3;
      default: c_idx = 2'd0;
    endcase
  end

  assign tick    = &div_q;
  assign row_any = ~&rs_q;
  assign code    = {r_idx, c_idx};
  assign col_rot = {col_q[2:0], col_q[3]};
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    rs1_d       = row;
    rs_d        = rs1_q;
    div_d       = div_q + DIV_ONE;
    state_d     = state_q;
    col_d       = col_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_value_d = key_value_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    accept      = 1'b0;
    acc_code    = cand_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_again_d = rpt_again_q;
    rpt_inc     = rpt_q + 9'd1;
    // Held at zero outside PRESSED, so it restarts on every entry.
    if (state_q != S_PRESS) begin
      rpt_d       = 9'd0;
      rpt_again_d = 1'b0;
    end
`endif

    if (tick) begin
      unique case (state_q)
        S_SCAN: begin
          if (!row_any) begin
            col_d = col_rot;
          end else begin
            cand_d = code;
            cnt_d  = 4'd1;
            if (DS == 4'd1) begin
              accept   = 1'b1;
              acc_code = code;
              state_d  = S_PRESS;
            end else begin
              state_d = S_DEB;
            end
          end
        end
        S_DEB: begin
          if (!row_any || code != cand_q) begin
            state_d = S_SCAN;
            col_d   = col_rot;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) begin
              accept   = 1'b1;
              acc_code = cand_q;
              state_d  = S_PRESS;
            end
          end
        end
        S_PRESS: begin
          if (!row_any) begin
            if (DS == 4'd1) begin
              state_d = S_SCAN;
              col_d   = col_rot;
            end else begin
              cnt_d   = 4'd1;
              state_d = S_REL;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rpt_inc == (rpt_again_q ? 9'd100 : 9'd500)) begin
              accept      = 1'b1;
              acc_code    = cand_q;
              rpt_d       = 9'd0;
              rpt_again_d = 1'b1;
            end else begin
              rpt_d = rpt_inc;
            end
`endif
          end
        end
        S_REL: begin
          if (row_any) begin
            state_d = S_PRESS;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) begin
              state_d = S_SCAN;
              col_d   = col_rot;
            end
          end
        end
      endcase
    end

    // An ack that coincides with acceptance consumes the old key only.
    if (accept) begin
      key_value_d = acc_code;
      key_valid_d = 1'b1;
      if (key_ack) begin
        overrun_d = 1'b0;
      end else if (key_valid_q) begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rs1_q       <= 4'hF;
      rs_q        <= 4'hF;
      div_q       <= '0;
      state_q     <= S_SCAN;
      col_q       <= 4'b1110;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_value_q <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= 9'd0;
      rpt_again_q <= 1'b0;
`endif
    end else begin
      rs1_q       <= rs1_d;
      rs_q        <= rs_d;
      div_q       <= div_d;
      state_q     <= state_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
      rpt_again_q <= rpt_again_d;
`endif
    end
  end

  assign col         = col_q;
  assign key_value   = key_value_q;
  assign key_valid   = key_valid_q;
  assign overrun     = overrun_q;
  assign key_pressed = (state_q == S_PRESS) || (state_q == S_REL);

endmodule

// File: tb/tb_keypad_4x4_scan.sv
// tb_keypad_4x4_scan: table-driven bench for keypad_4x4_scan with a
// modelled key matrix; scan tick every 16 clk, 3-scan debounce.
module tb_keypad_4x4_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_pressed;
  logic       overrun;

  logic       key_en = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] div_m = 4'd0;

  int n_vec = 0;
  int n_err = 0;

  keypad_4x4_scan #(
    .SCAN_DIV_BITS (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .key_value  (key_value),
    .key_valid  (key_valid),
    .key_ack    (key_ack),
    .key_pressed(key_pressed),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference divider: a posedge with div_m==15 beforehand is a tick edge.
  always @(posedge clk) div_m <= !rst ? 4'd0 : div_m + 4'd1;

  // Key matrix: row r pulled low only while key (r,c) is down and col c low.
  always_comb begin
    row = 4'hF;
    if (key_en && col[key_code[1:0]] === 1'b0) row[key_code[3:2]] = 1'b0;
  end

  typedef struct {
    int         nt;
    logic       en;
    logic [3:0] key;
    logic [3:0] col;
    logic       valid;
    logic [3:0] val;
    logic       pr;
    logic       ov;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string nm, input logic [10:0] act,
                       input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {col, key_valid, key_value, key_pressed, overrun};
  endfunction

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) begin
      do @(posedge clk); while (div_m != 4'd15);
    end
    @(negedge clk);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      key_en   = tbl[i].en;
      key_code = tbl[i].key;
      ticks(tbl[i].nt);
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].col, tbl[i].valid, tbl[i].val, tbl[i].pr, tbl[i].ov});
    end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  initial begin
    int ev;
    //           nt en key  col      v val pr ov
    tbl[0]  = '{1, 0, 0,  4'b1101, 0, 0,  0, 0};
    tbl[1]  = '{1, 0, 0,  4'b1011, 0, 0,  0, 0};
    tbl[2]  = '{1, 0, 0,  4'b0111, 0, 0,  0, 0};
    tbl[3]  = '{1, 0, 0,  4'b1110, 0, 0,  0, 0};
    tbl[4]  = '{2, 1, 6,  4'b1011, 0, 0,  0, 0};
    tbl[5]  = '{1, 1, 6,  4'b1011, 0, 0,  0, 0};
    tbl[6]  = '{1, 1, 6,  4'b1011, 0, 0,  0, 0};
    tbl[7]  = '{1, 1, 6,  4'b1011, 1, 6,  1, 0};
    tbl[8]  = '{2, 0, 0,  4'b1011, 0, 6,  1, 0};
    tbl[9]  = '{1, 0, 0,  4'b0111, 0, 6,  0, 0};
    tbl[10] = '{1, 1, 12, 4'b1110, 0, 6,  0, 0};
    tbl[11] = '{1, 1, 12, 4'b1110, 0, 6,  0, 0};
    tbl[12] = '{1, 0, 0,  4'b1101, 0, 6,  0, 0};
    tbl[13] = '{1, 1, 5,  4'b1101, 0, 6,  0, 0};
    tbl[14] = '{2, 1, 5,  4'b1101, 1, 5,  1, 0};
    tbl[15] = '{3, 0, 0,  4'b1011, 1, 5,  0, 0};
    tbl[16] = '{3, 1, 10, 4'b1011, 1, 10, 1, 1};
    tbl[17] = '{3, 0, 0,  4'b0111, 0, 10, 0, 0};
    tbl[18] = '{3, 1, 3,  4'b0111, 1, 3,  1, 0};
    tbl[19] = '{3, 0, 0,  4'b1110, 1, 3,  0, 0};
    tbl[20] = '{3, 1, 15, 4'b0111, 1, 3,  0, 0};
    tbl[21] = '{2, 1, 15, 4'b0111, 1, 3,  0, 0};
    tbl[22] = '{3, 1, 15, 4'b0111, 0, 0,  0, 0};
    tbl[23] = '{2, 1, 15, 4'b0111, 0, 0,  0, 0};
    tbl[24] = '{1, 1, 15, 4'b0111, 1, 15, 1, 0};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", outs(), {4'b1110, 1'b0, 4'd0, 1'b0, 1'b0});
    rst = 1'b1;

    run(0, 7);

    ack_pulse();
    check("ack_clear", outs(), {4'b1011, 1'b0, 4'd6, 1'b1, 1'b0});

    ev = 0;
    for (int i = 0; i < 50; i++) begin
      ticks(1);
      if (key_valid) ev++;
    end
    check("hold_no_repeat", {key_pressed, 10'(ev)}, {1'b1, 10'd0});

    run(8, 16);

    ack_pulse();
    check("overrun_ack", outs(), {4'b1011, 1'b0, 4'hA, 1'b1, 1'b0});

    run(17, 21);

    // Raise ack for exactly the cycle whose posedge accepts key 0xF.
    for (int i = 0; i < 32 && div_m != 4'd15; i++) @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("ack_on_accept", outs(), {4'b0111, 1'b1, 4'hF, 1'b1, 1'b0});

    rst = 1'b0;
    @(negedge clk);
    check("reset_pressed", outs(), {4'b1110, 1'b0, 4'd0, 1'b0, 1'b0});
    rst = 1'b1;

    run(22, 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
